stream_delay_align: RTL and testbench

STREAM_DELAY_ALIGN -- requirements
Module: stream_delay_align

---
 rtl/stream_delay_align.sv | 167 ++++++++++++++++
 tb/tb_stream_delay_align.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/stream_delay_align.sv
// Fixed-latency stream delay line: delays {in_vld, in_data} by a configurable
// number of clock cycles through a circular buffer, with refill tracking after reconfiguration.
module stream_delay_align #(
    parameter int DATA_W  = 16,
    parameter int MAX_DLY = 64,
    parameter int DLY_W   = $clog2(MAX_DLY + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DLY_W-1:0]  dly_cfg,
    input  logic              dly_load,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              cfg_err
);

    localparam int PTR_W = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    function automatic logic cfg_bad(input logic [DLY_W-1:0] cfg);
        return (cfg == {DLY_W{1'b0}}) || (cfg > DLY_W'(MAX_DLY));
    endfunction

    // Zero requests the shortest legal delay; oversize requests clamp to the buffer depth.
    function automatic logic [DLY_W-1:0] cfg_to_dly(input logic [DLY_W-1:0] cfg);
        if (cfg == {DLY_W{1'b0}}) begin
            return DLY_W'(1);
        end else if (cfg > DLY_W'(MAX_DLY)) begin
            return DLY_W'(MAX_DLY);
        end else begin
            return cfg;
        end
    endfunction

    state_t             state_r, state_s;
    logic [DLY_W-1:0]   fill_r, fill_s;
    logic [DLY_W-1:0]   d_act_r, d_act_s;
    logic [PTR_W-1:0]   wr_ptr_r, wr_ptr_s;
    logic [PTR_W-1:0]   rd_idx_s;
    logic [DLY_W:0]     wr_ext_s, d_ext_s, rd_ext_s;
    logic [MAX_DLY-1:0] vbit_r;
    logic [DATA_W-1:0]  mem_r [MAX_DLY];
    logic               rd_ok_s;
    logic               out_vld_r, busy_r, cfg_err_r;
    logic [DATA_W-1:0]  out_data_r;

    // Next-state and fill counter; a load overrides whatever the current state decided.
    always_comb begin
        state_s = state_r;
        fill_s  = fill_r;
        if (dly_load) begin
            d_act_s = cfg_to_dly(dly_cfg);
        end else begin
            d_act_s = d_act_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (in_vld) begin
                    if (d_act_s == DLY_W'(1)) begin
                        state_s = ST_RUN;
                        fill_s  = DLY_W'(0);
                    end else begin
                        state_s = ST_FILL;
                        fill_s  = d_act_s - DLY_W'(1);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (fill_r <= DLY_W'(1)) begin
                    state_s = ST_RUN;
                    fill_s  = DLY_W'(0);
                end else begin
                    fill_s = fill_r - DLY_W'(1);
                end
            end
            ST_RUN: begin
                state_s = ST_RUN;
            end
            default: begin
                state_s = ST_IDLE;
                fill_s  = DLY_W'(0);
            end
        endcase
        if (dly_load) begin
            if (d_act_s == DLY_W'(1)) begin
                state_s = ST_RUN;
                fill_s  = DLY_W'(0);
            end else begin
                state_s = ST_FILL;
                fill_s  = d_act_s - DLY_W'(1);
            end
        end else begin
            fill_s = fill_s;
        end
    end

    // Pointer arithmetic: read lags write by D_act, wrapped into 0..MAX_DLY-1.
    always_comb begin
        wr_ext_s = (DLY_W + 1)'(wr_ptr_r);
        d_ext_s  = (DLY_W + 1)'(d_act_r);
        if (wr_ext_s >= d_ext_s) begin
            rd_ext_s = wr_ext_s - d_ext_s;
        end else begin
            rd_ext_s = wr_ext_s + (DLY_W + 1)'(MAX_DLY) - d_ext_s;
        end
        rd_idx_s = PTR_W'(rd_ext_s);
        if (wr_ptr_r == PTR_W'(MAX_DLY - 1)) begin
            wr_ptr_s = PTR_W'(0);
        end else begin
            wr_ptr_s = wr_ptr_r + PTR_W'(1);
        end
        // The load edge itself still reads the old geometry, so it is suppressed.
        rd_ok_s = !dly_load && (state_s == ST_RUN) && vbit_r[rd_idx_s];
    end

    // Control state, valid bits and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            fill_r     <= DLY_W'(0);
            d_act_r    <= DLY_W'(MAX_DLY);
            wr_ptr_r   <= PTR_W'(0);
            vbit_r     <= {MAX_DLY{1'b0}};
            out_vld_r  <= 1'b0;
            out_data_r <= {DATA_W{1'b0}};
            busy_r     <= 1'b0;
            cfg_err_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            fill_r     <= fill_s;
            d_act_r    <= d_act_s;
            wr_ptr_r   <= wr_ptr_s;
            if (dly_load) begin
                vbit_r           <= {MAX_DLY{1'b0}};
                vbit_r[wr_ptr_r] <= in_vld;
                cfg_err_r        <= cfg_bad(dly_cfg);
            end else begin
                vbit_r[wr_ptr_r] <= in_vld;
                cfg_err_r        <= cfg_err_r;
            end
            out_vld_r  <= rd_ok_s;
            out_data_r <= rd_ok_s ? mem_r[rd_idx_s] : {DATA_W{1'b0}};
            busy_r     <= (state_s == ST_FILL);
        end
    end

    // Payload storage; contents are qualified by vbit_r so no reset is needed.
    always_ff @(posedge clk) begin
        mem_r[wr_ptr_r] <= in_data;
    end

    assign out_vld  = out_vld_r;
    assign out_data = out_data_r;
    assign busy     = busy_r;
    assign cfg_err  = cfg_err_r;

endmodule

// File: tb/tb_stream_delay_align.sv
// Directed + randomized bench for stream_delay_align against a cycle-history
// reference model: output at cycle n is the input of cycle n-D within the current epoch.
module tb_stream_delay_align;
    localparam int DATA_W  = 16;
    localparam int MAX_DLY = 64;
    localparam int DLY_W   = 7;
    localparam int HIST    = 4096;

    logic              clk, rst_n;
    logic [DLY_W-1:0]  dly_cfg;
    logic              dly_load, in_vld;
    logic [DATA_W-1:0] in_data;
    logic              out_vld, busy, cfg_err;
    logic [DATA_W-1:0] out_data;

    stream_delay_align #(.DATA_W(DATA_W), .MAX_DLY(MAX_DLY), .DLY_W(DLY_W)) dut (
        .clk(clk), .rst_n(rst_n), .dly_cfg(dly_cfg), .dly_load(dly_load),
        .in_vld(in_vld), .in_data(in_data), .out_vld(out_vld),
        .out_data(out_data), .busy(busy), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int          n = 0;
    bit          h_vld [HIST];
    logic [15:0] h_dat [HIST];
    int          m_d, m_epoch, m_start;
    bit          m_started, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic model_reset();
        m_d = MAX_DLY; m_err = 1'b0; m_started = 1'b0; m_epoch = n; m_start = 0;
    endtask

    task automatic step(input bit ld, input int cfg, input bit v, input logic [15:0] d);
        int  idx;
        bit  ev, eb;
        logic [15:0] ed;
        dly_load = ld; dly_cfg = DLY_W'(cfg); in_vld = v; in_data = d;
        @(posedge clk);
        if (ld) begin
            if (cfg == 0) begin m_d = 1; m_err = 1'b1; end
            else if (cfg > MAX_DLY) begin m_d = MAX_DLY; m_err = 1'b1; end
            else begin m_d = cfg; m_err = 1'b0; end
            m_epoch = n; m_started = 1'b1; m_start = n;
        end else if (!m_started && v) begin
            m_started = 1'b1; m_start = n;
        end
        h_vld[n] = v; h_dat[n] = d;
        ev = 1'b0; ed = 16'h0;
        if (!ld) begin
            idx = n - m_d;
            if (idx >= m_epoch && h_vld[idx]) begin ev = 1'b1; ed = h_dat[idx]; end
        end
        eb = m_started && ((n - m_start) < (m_d - 1));
        #1;
        chk("out_vld",  32'(out_vld),  32'(ev));
        chk("out_data", 32'(out_data), 32'(ed));
        chk("busy",     32'(busy),     32'(eb));
        chk("cfg_err",  32'(cfg_err),  32'(m_err));
        n++;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_vld"},  32'(out_vld),  32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy),     32'd0);
        chk({tag, "_err"},  32'(cfg_err),  32'd0);
    endtask

    initial begin
        int ramp;
        rst_n = 1'b0; dly_load = 1'b0; dly_cfg = '0; in_vld = 1'b0; in_data = '0;
        #12;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        model_reset();

        // idle, then default delay of MAX_DLY after the first valid
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 16'h0);
        for (int i = 0; i < 70; i++) step(1'b0, 0, 1'b1, 16'(16'h100 + i));

        // fixed delay of 5 with a continuous ramp
        ramp = 1;
        step(1'b1, 5, 1'b1, 16'(ramp));
        for (int i = 0; i < 19; i++) begin ramp++; step(1'b0, 0, 1'b1, 16'(ramp)); end

        // gap preservation at D=3
        step(1'b1, 3, 1'b1, 16'hA001);
        step(1'b0, 0, 1'b0, 16'hA002);
        step(1'b0, 0, 1'b0, 16'hA003);
        step(1'b0, 0, 1'b1, 16'hA004);
        step(1'b0, 0, 1'b1, 16'hA005);
        for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b0, 16'h0);

        // out-of-range configurations and recovery
        step(1'b1, 0, 1'b1, 16'hB000);
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1, 16'(16'hB001 + i));
        step(1'b1, MAX_DLY + 1, 1'b1, 16'hC000);
        for (int i = 0; i < 70; i++) step(1'b0, 0, 1'b1, 16'(16'hC001 + i));
        step(1'b1, 4, 1'b1, 16'hD000);
        for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1, 16'(16'hD001 + i));

        // reconfigure mid-stream from D=8 to D=2
        step(1'b1, 8, 1'b1, 16'hE000);
        for (int i = 0; i < 20; i++) step(1'b0, 0, 1'b1, 16'(16'hE001 + i));
        step(1'b1, 2, 1'b1, 16'hF000);
        for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b1, 16'(16'hF001 + i));

        // full-depth delay across several pointer wraps
        step(1'b1, MAX_DLY, 1'b1, 16'($urandom));
        for (int i = 0; i < 199; i++) step(1'b0, 0, 1'b1, 16'($urandom));

        // random traffic with occasional reloads, including mid-fill
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 19) == 0, int'($urandom_range(0, 70)),
                 1'($urandom_range(0, 1)), 16'($urandom));

        // async reset while running with cfg_err set
        step(1'b1, 0, 1'b1, 16'h1234);
        for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b1, 16'(16'h2000 + i));
        #3;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        in_vld = 1'b1; in_data = 16'hDEAD; dly_load = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero_outputs("held_rst");
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0, 16'h0);
        for (int i = 0; i < 80; i++) step(1'b0, 0, 1'($urandom_range(0, 1)), 16'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
